mem_req_resp: RTL and testbench

//  Parametrised byte-addressed data memory with per-byte write strobes and a valid/ready

---
 rtl/mem_req_resp.sv | 141 ++++++++++++++
 tb/tb_mem_req_resp.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_req_resp.sv
// mem_req_resp: byte-addressed data memory with strobed writes, valid/ready request/response and a power-up clear engine
module mem_req_resp #(
  parameter int ADDR_WIDTH       = 16,
  parameter int DATA_WIDTH_BYTES = 4,
  parameter int MEM_SIZE_BYTES   = 4096,
  parameter int READ_LATENCY     = 1,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH_BYTES-1:0]   req_wstrb,
  input  logic [8*DATA_WIDTH_BYTES-1:0] req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [8*DATA_WIDTH_BYTES-1:0] resp_rdata,
  output logic                          resp_err
);
  localparam int DW    = 8 * DATA_WIDTH_BYTES;
  localparam int MAW   = $clog2(MEM_SIZE_BYTES);
  localparam int WORDS = MEM_SIZE_BYTES / DATA_WIDTH_BYTES;
  localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int QD    = READ_LATENCY + 1;
  localparam int QW    = $clog2(QD);
  localparam int CW    = $clog2(QD + 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            r_state;
  logic [WAW-1:0]    r_clr_ptr;
  logic [7:0]        r_mem [MEM_SIZE_BYTES];
  logic [DW-1:0]     r_q_d [QD];
  logic              r_q_e [QD];
  logic [QW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_q_cnt, r_out;
  logic [MAW-1:0]    w_idx [DATA_WIDTH_BYTES];
  logic [MAW-1:0]    w_clr_base;
  logic [DW-1:0]     w_rdata, w_enq_d;
  logic              w_err, w_acc, w_deq, w_enq_v, w_enq_e;

  // A request is accepted only in RUN and only while every possible response has a queue slot,
  // so the queue can never overflow and backpressure never reaches req_ready combinationally.
  assign req_ready  = (r_state == S_RUN) && (r_out < CW'(QD));
  assign w_acc      = req_valid && req_ready;
  assign resp_valid = r_q_cnt != '0;
  assign w_deq      = resp_valid && resp_ready;
  assign resp_rdata = resp_valid ? r_q_d[r_rp] : '0;
  assign resp_err   = resp_valid && r_q_e[r_rp];
  assign w_clr_base = MAW'(r_clr_ptr) * MAW'(DATA_WIDTH_BYTES);
  assign w_err      = ({1'b0, req_addr} >= (ADDR_WIDTH + 1)'(MEM_SIZE_BYTES)) ||
                      (ALLOW_MISALIGNED == 0 && (req_addr % ADDR_WIDTH'(DATA_WIDTH_BYTES)) != '0);

  // Lane addresses wrap at the top of memory; written lanes and errored requests return zero
  always_comb begin
    w_idx   = '{default: '0};
    w_rdata = '0;
    for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
      w_idx[i]         = req_addr[MAW-1:0] + MAW'(i);
      w_rdata[8*i +: 8] = (w_err || req_wstrb[i]) ? 8'h00 : r_mem[w_idx[i]];
    end
  end

  // Clear engine: one word per cycle after reset, then RUN until the next reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_ptr <= r_clr_ptr + 1'b1;
      if (r_clr_ptr == WAW'(WORDS - 1)) r_state <= S_RUN;
    end
  end

  // Storage: clearing writes zeros, accepted valid requests write their strobed lanes
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      for (int j = 0; j < DATA_WIDTH_BYTES; j++) r_mem[w_clr_base + MAW'(j)] <= 8'h00;
    end else if (w_acc && !w_err) begin
      for (int i = 0; i < DATA_WIDTH_BYTES; i++) if (req_wstrb[i]) r_mem[w_idx[i]] <= req_wdata[8*i +: 8];
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign w_enq_v = w_acc;
      assign w_enq_d = w_rdata;
      assign w_enq_e = w_err;
    end else begin : g_pipe
      logic          r_v [READ_LATENCY-1];
      logic          r_e [READ_LATENCY-1];
      logic [DW-1:0] r_d [READ_LATENCY-1];
      // Delay line so responses reach the queue READ_LATENCY-1 edges after acceptance
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < READ_LATENCY - 1; j++) begin
            r_v[j] <= 1'b0;
            r_e[j] <= 1'b0;
            r_d[j] <= '0;
          end
        end else begin
          r_v[0] <= w_acc;
          r_e[0] <= w_err;
          r_d[0] <= w_rdata;
          for (int j = 1; j < READ_LATENCY - 1; j++) begin
            r_v[j] <= r_v[j-1];
            r_e[j] <= r_e[j-1];
            r_d[j] <= r_d[j-1];
          end
        end
      end
      assign w_enq_v = r_v[READ_LATENCY-2];
      assign w_enq_d = r_d[READ_LATENCY-2];
      assign w_enq_e = r_e[READ_LATENCY-2];
    end
  endgenerate

  // In-order response queue plus the accepted-minus-consumed counter that throttles acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < QD; j++) begin
        r_q_d[j] <= '0;
        r_q_e[j] <= 1'b0;
      end
      r_wp    <= '0;
      r_rp    <= '0;
      r_q_cnt <= '0;
      r_out   <= '0;
    end else begin
      if (w_enq_v) begin
        r_q_d[r_wp] <= w_enq_d;
        r_q_e[r_wp] <= w_enq_e;
        r_wp        <= (r_wp == QW'(QD - 1)) ? '0 : r_wp + 1'b1;
      end
      if (w_deq) r_rp <= (r_rp == QW'(QD - 1)) ? '0 : r_rp + 1'b1;
      r_q_cnt <= r_q_cnt + CW'(w_enq_v) - CW'(w_deq);
      r_out   <= r_out + CW'(w_acc) - CW'(w_deq);
    end
  end
endmodule

// File: tb/tb_mem_req_resp.sv
// tb_mem_req_resp: scoreboard bench over READ_LATENCY 1..4, one instance with misaligned access disallowed
module tb_mem_req_resp;
  logic clk = 1'b0;
  int checks = 0, errors = 0, n_done = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int L  = g + 1;
    localparam int AM = (g == 1) ? 0 : 1;
    logic        rst = 1'b1, req_valid = 1'b0, resp_ready = 1'b1;
    logic        req_ready, resp_valid, resp_err;
    logic [15:0] req_addr = '0;
    logic [3:0]  req_wstrb = '0;
    logic [31:0] req_wdata = '0, resp_rdata;
    logic [7:0]  model [4096];
    logic [32:0] sb [$];
    logic        hold = 1'b0;
    logic [32:0] held = '0;

    mem_req_resp #(.READ_LATENCY(L), .ALLOW_MISALIGNED(AM)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    function automatic string t(input string s);
      return $sformatf("L%0d_%s", L, s);
    endfunction

    always @(negedge clk) begin
      if (rst) hold = 1'b0;
      else begin
        if (hold) begin
          check(t("hold_valid"), 64'(resp_valid), 64'd1);
          check(t("hold_data"), 64'({resp_err, resp_rdata}), 64'(held));
        end
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) check(t("extra_resp"), 64'(resp_valid), 64'd0);
          else begin
            logic [32:0] e;
            e = sb.pop_front();
            check(t("rdata"), 64'(resp_rdata), 64'(e[31:0]));
            check(t("err"), 64'(resp_err), 64'(e[32]));
          end
        end
        hold = resp_valid && !resp_ready;
        held = {resp_err, resp_rdata};
      end
    end

    task automatic drive(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
      req_valid = 1'b1;
      req_addr  = a;
      req_wstrb = s;
      req_wdata = d;
    endtask

    function automatic void predict();
      logic [32:0] e;
      e = '0;
      e[32] = (req_addr >= 16'h1000) || (AM == 0 && req_addr[1:0] != 2'b00);
      if (!e[32]) for (int i = 0; i < 4; i++) begin
        int b = (int'(req_addr) + i) % 4096;
        if (req_wstrb[i]) model[b] = req_wdata[8*i +: 8];
        else e[8*i +: 8] = model[b];
      end
      sb.push_back(e);
    endfunction

    task automatic req(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
      drive(a, s, d);
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (req_ready) break;
      end
      check(t("req_accept"), 64'(req_ready), 64'd1);
      if (req_ready) predict();
      @(posedge clk); #1;
    endtask

    task automatic idle_drain();
      req_valid = 1'b0;
      for (int c = 0; c < 100 && sb.size() != 0; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      check(t("drain"), 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
    endtask

    task automatic do_reset();
      int c = 0;
      rst = 1'b1;
      req_valid = 1'b0;
      sb.delete();
      for (int i = 0; i < 4096; i++) model[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check(t("rst_req_ready"), 64'(req_ready), 64'd0);
      check(t("rst_resp_valid"), 64'(resp_valid), 64'd0);
      check(t("rst_rdata"), 64'(resp_rdata), 64'd0);
      check(t("rst_err"), 64'(resp_err), 64'd0);
      rst = 1'b0;
      while (!req_ready && c < 3000) begin
        @(posedge clk); #1;
        c++;
      end
      check(t("clear_cycles"), 64'(c), 64'd1024);
    endtask

    initial begin
      int acc;
      do_reset();
      req(16'h0FFC, 4'h0, 32'h0);
      req(16'h0010, 4'hF, 32'hDEADBEEF);
      req(16'h0010, 4'h0, 32'h0);
      req(16'h0010, 4'h5, 32'h11223344);
      req(16'h0010, 4'h0, 32'h0);
      req(16'h1000, 4'hF, 32'h12345678);
      req(16'h0002, 4'h0, 32'h0);
      req(16'h0002, 4'hF, 32'h55555555);
      req(16'h0010, 4'h0, 32'h0);
      req(16'h0FFE, 4'hF, 32'hAABBCCDD);
      req(16'h0FFC, 4'h0, 32'h0);
      req(16'h0000, 4'h0, 32'h0);
      for (int n = 0; n < 10; n++) req(16'h0200 + 16'(4 * n), 4'hF, 32'h5A000000 | 32'(n));
      idle_drain();
      resp_ready = 1'b0;
      acc = 0;
      for (int cyc = 0; cyc < 200 && acc < 10; cyc++) begin
        if (cyc == 5) begin
          check(t("bp_accepts"), 64'(acc), 64'(L + 1));
          check(t("bp_stall"), 64'(req_ready), 64'd0);
          resp_ready = 1'b1;
        end
        drive(16'h0200 + 16'(4 * acc), 4'h0, 32'h0);
        @(negedge clk);
        if (req_ready) begin
          predict();
          acc++;
        end
        @(posedge clk); #1;
      end
      check(t("bp_all_accepted"), 64'(acc), 64'd10);
      idle_drain();
      resp_ready = 1'b0;
      for (int k = 0; k < ((L < 2) ? L + 1 : 3); k++) req(16'h0100 + 16'(4 * k), 4'hF, 32'hC0DE0000 | 32'(k));
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check(t("rst_async_valid"), 64'(resp_valid), 64'd0);
      resp_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 3; k++) req(16'h0100 + 16'(4 * k), 4'h0, 32'h0);
      idle_drain();
      n_done++;
    end
  end

  initial begin
    for (int c = 0; c < 20000 && n_done < 4; c++) @(posedge clk);
    check("all_done", 64'(n_done), 64'd4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
